// File: rtl/serial_to_parallel_8bit_pkg.sv
// Shared constants and FSM state encoding for the serial-to-parallel framer.
package serial_to_parallel_8bit_pkg;

  localparam int         WORD_W  = 8;
  localparam logic [7:0] ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/serial_to_parallel_8bit_sat_counter.sv
// 8-bit error counter: counts increment requests and sticks at ERR_MAX.
module sat_counter_8bit
  import serial_to_parallel_8bit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output logic [WORD_W-1:0] count_o
);

  logic [WORD_W-1:0] count_q;
  logic [WORD_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != ERR_MAX)) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/serial_to_parallel_8bit.sv
// Serial framer: assembles 8 data bits (plus optional even parity) into a word.
// Handshake: par_valid and clr_req are one-cycle strobes registered on CLK; never both high.
module serial_to_parallel_8bit
  import serial_to_parallel_8bit_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              async_clr,
  input  logic              ser_start,
  input  logic              ser_en,
  input  logic              ser_in,
  output logic [WORD_W-1:0] par_out,
  output logic              par_valid,
  output logic              clr_req,
  output logic              busy,
  output logic [WORD_W-1:0] err_count,
  output logic [1:0]        dbg_state
);

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-1:0] sreg_d;
  logic [WORD_W-1:0] par_out_q;
  logic              par_valid_q;
  logic              clr_req_q;
  logic              busy_q;
  logic              parity_bad_d;

  always_comb begin
    sreg_d = {sreg_q[6:0], ser_in};
    if (!MSB_FIRST) sreg_d = {ser_in, sreg_q[7:1]};
  end

  // ser_start wins over a parity bit in the same cycle: the frame is aborted, not judged.
  assign parity_bad_d = (state_q == PARITY) && ser_en && !ser_start && (^{sreg_q, ser_in});

  always_ff @(posedge CLK or posedge async_clr) begin
    if (async_clr) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      clr_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      par_valid_q <= 1'b0;
      clr_req_q   <= 1'b0;
      if (ser_start) begin
        state_q   <= SHIFT;
        bit_cnt_q <= '0;
        sreg_q    <= '0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            if (ser_en) begin
              sreg_q    <= sreg_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (PARITY_EN) begin
                  state_q <= PARITY;
                end else begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  par_out_q   <= sreg_d;
                  par_valid_q <= 1'b1;
                end
              end
            end
          end
          PARITY: begin
            if (ser_en) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (parity_bad_d) begin
                clr_req_q <= 1'b1;
              end else begin
                par_out_q   <= sreg_q;
                par_valid_q <= 1'b1;
              end
            end
          end
          IDLE: begin
            busy_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter_8bit u_err_cnt (
    .clk_i   (CLK),
    .rst_i   (async_clr),
    .inc_i   (parity_bad_d),
    .count_o (err_count)
  );

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign clr_req   = clr_req_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_to_parallel_8bit.sv
// Bench for the serial framer: MSB-first and LSB-first parity instances share stimulus,
// a third no-parity instance has its own inputs; a frame-level model feeds scoreboards.
module tb_serial_to_parallel_8bit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic async_clr, ser_start, ser_en, ser_in;
  logic start_c, en_c, in_c;

  logic [7:0] po_a, ec_a, po_b, ec_b, po_c, ec_c;
  logic       pv_a, cr_a, busy_a, pv_b, cr_b, busy_b, pv_c, cr_c, busy_c;
  logic [1:0] st_a, st_b, st_c;

  serial_to_parallel_8bit #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
    .CLK(CLK), .async_clr(async_clr), .ser_start(ser_start), .ser_en(ser_en), .ser_in(ser_in),
    .par_out(po_a), .par_valid(pv_a), .clr_req(cr_a), .busy(busy_a), .err_count(ec_a),
    .dbg_state(st_a));

  serial_to_parallel_8bit #(.MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_b (
    .CLK(CLK), .async_clr(async_clr), .ser_start(ser_start), .ser_en(ser_en), .ser_in(ser_in),
    .par_out(po_b), .par_valid(pv_b), .clr_req(cr_b), .busy(busy_b), .err_count(ec_b),
    .dbg_state(st_b));

  serial_to_parallel_8bit #(.MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_c (
    .CLK(CLK), .async_clr(async_clr), .ser_start(start_c), .ser_en(en_c), .ser_in(in_c),
    .par_out(po_c), .par_valid(pv_c), .clr_req(cr_c), .busy(busy_c), .err_count(ec_c),
    .dbg_state(st_c));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pv_last = 0;
  int pv_prev = 0;

  // Entry: {1 = word delivered / 0 = parity error, expected par_out, expected err_count}
  logic [16:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];
  logic [16:0] exp_c_q[$];
  logic [7:0]  hold_word[3];
  logic [7:0]  model_last[3];
  int          err_m[3];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model: the i-th transmitted bit lands in bit 7-i (MSB first) or bit i (LSB first).
  function automatic logic [7:0] model_word(input logic [7:0] seq, input bit msb);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (msb) w[7-i] = seq[i];
      else     w[i]   = seq[i];
    end
    return w;
  endfunction

  task automatic push_ab(input logic [7:0] seq, input logic par);
    int ones;
    bit bad;
    logic [7:0] w;
    ones = par;
    for (int i = 0; i < 8; i++) ones += seq[i];
    bad = (ones % 2) == 1;
    for (int k = 0; k < 2; k++) begin
      w = model_word(seq, k == 0);
      if (bad) begin
        if (err_m[k] < 255) err_m[k]++;
      end else begin
        model_last[k] = w;
      end
      if (k == 0) exp_a_q.push_back({~bad, model_last[k], 8'(err_m[k])});
      else        exp_b_q.push_back({~bad, model_last[k], 8'(err_m[k])});
    end
  endtask

  // gap_at in 0..8 inserts gap_len idle ser_en cycles before that bit (8 = before parity).
  task automatic send_ab(input logic [7:0] seq, input logic par, input int gap_at, input int gap_len);
    ser_start = 1'b1; ser_en = 1'b0; tick();
    ser_start = 1'b0;
    chk("busy_a_in_frame", busy_a, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == gap_at) begin
        ser_en = 1'b0;
        repeat (gap_len) tick();
      end
      ser_en = 1'b1;
      ser_in = (i < 8) ? seq[i] : par;
      if (i == 8) push_ab(seq, par);
      tick();
    end
    ser_en = 1'b0;
  endtask

  task automatic abort_ab(input int n_bits);
    ser_start = 1'b1; ser_en = 1'b0; tick();
    ser_start = 1'b0;
    for (int i = 0; i < n_bits; i++) begin
      ser_en = 1'b1; ser_in = 1'($urandom); tick();
    end
    ser_en = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] seq);
    start_c = 1'b1; en_c = 1'b0; tick();
    start_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en_c = 1'b1; in_c = seq[i];
      if (i == 7) begin
        model_last[2] = model_word(seq, 1'b1);
        exp_c_q.push_back({1'b1, model_last[2], 8'h00});
      end
      tick();
    end
    en_c = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_a_q.size() + exp_b_q.size() + exp_c_q.size()) != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("drain_timeout", exp_a_q.size() + exp_b_q.size() + exp_c_q.size(), 0);
  endtask

  task automatic mon(input int id, input logic pv, input logic cr, input logic [7:0] po,
                     input logic [7:0] ec);
    logic [16:0] e;
    bit have;
    string nm;
    nm = (id == 0) ? "a" : (id == 1) ? "b" : "c";
    e = '0;
    chk({"excl_", nm}, pv & cr, 0);
    if (pv || cr) begin
      have = 1'b0;
      if (id == 0 && exp_a_q.size() > 0) begin e = exp_a_q.pop_front(); have = 1'b1; end
      else if (id == 1 && exp_b_q.size() > 0) begin e = exp_b_q.pop_front(); have = 1'b1; end
      else if (id == 2 && exp_c_q.size() > 0) begin e = exp_c_q.pop_front(); have = 1'b1; end
      chk({"strobe_expected_", nm}, have, 1);
      if (have) begin
        chk({"kind_", nm}, pv, e[16]);
        chk({"par_out_", nm}, po, e[15:8]);
        chk({"err_count_", nm}, ec, e[7:0]);
        if (pv) hold_word[id] = e[15:8];
      end
    end else begin
      chk({"hold_", nm}, po, hold_word[id]);
    end
  endtask

  always @(negedge CLK or posedge async_clr) begin
    if (async_clr) begin
      for (int i = 0; i < 3; i++) hold_word[i] = '0;
    end else begin
      mon(0, pv_a, cr_a, po_a, ec_a);
      mon(1, pv_b, cr_b, po_b, ec_b);
      mon(2, pv_c, cr_c, po_c, ec_c);
      if (pv_a) begin
        pv_prev = pv_last;
        pv_last = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_par_out"}, {po_a, po_b, po_c}, 0);
    chk({tag, "_par_valid"}, {pv_a, pv_b, pv_c}, 0);
    chk({tag, "_clr_req"}, {cr_a, cr_b, cr_c}, 0);
    chk({tag, "_busy"}, {busy_a, busy_b, busy_c}, 0);
    chk({tag, "_err_count"}, {ec_a, ec_b, ec_c}, 0);
    chk({tag, "_state"}, {st_a, st_b, st_c}, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      model_last[i] = '0;
      err_m[i] = 0;
    end
  endtask

  initial begin
    logic [7:0] seq;
    logic       par;
    async_clr = 1'b1;
    ser_start = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
    start_c = 1'b0; en_c = 1'b0; in_c = 1'b0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    async_clr = 1'b0;
    tick();

    // Directed frames: 1,0,1,0,0,1,0,1 -> A5 on both orders; 1,1,0,... -> C0 / 03.
    send_ab(8'hA5, 1'b0, 9, 0);
    drain();
    chk("a5_msb", po_a, 8'hA5);
    chk("a5_lsb", po_b, 8'hA5);
    send_ab(8'h03, 1'b0, 9, 0);
    drain();
    chk("03_msb", po_a, 8'hC0);
    chk("03_lsb", po_b, 8'h03);

    // Parity error on FF + parity 1.
    send_ab(8'hFF, 1'b1, 9, 0);
    drain();
    chk("perr_hold_a", po_a, 8'hC0);
    chk("perr_cnt_a", ec_a, 8'd1);

    // Aborts in SHIFT and in PARITY, then a gapped frame.
    abort_ab(4);
    send_ab(8'h5A, 1'b0, 9, 0);
    abort_ab(8);
    send_ab(8'h96, 1'b0, 9, 0);
    send_ab(8'h71, 1'b0, 3, 5);
    drain();
    chk("gap_msb", po_a, model_word(8'h71, 1'b1));

    // Back-to-back: ser_start lands in the par_valid cycle.
    send_ab(8'h81, 1'b0, 9, 0);
    send_ab(8'h3C, 1'b0, 9, 0);
    drain();
    chk("b2b_spacing", pv_last - pv_prev, 10);
    chk("b2b_word", po_a, 8'h3C);

    // Random frames with random parity, gaps and occasional aborts.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) abort_ab($urandom_range(0, 8));
      seq = 8'($urandom);
      par = 1'($urandom_range(0, 1));
      send_ab(seq, par, $urandom_range(0, 9), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end
    drain();

    // 256 parity errors saturate the counter.
    for (int n = 0; n < 256; n++) begin
      seq = 8'($urandom);
      par = ~(^seq);
      send_ab(seq, par, 9, 0);
    end
    drain();
    chk("sat_a", ec_a, 8'd255);
    chk("sat_b", ec_b, 8'd255);

    // No-parity instance: one directed and several random, back-to-back frames.
    send_c(8'hA5);
    for (int n = 0; n < 6; n++) send_c(8'($urandom));
    send_c(8'h03);
    drain();
    chk("c_word", po_c, 8'hC0);
    chk("c_err", ec_c, 8'd0);

    // Asynchronous reset mid-frame, between clock edges.
    ser_start = 1'b1; tick();
    ser_start = 1'b0;
    for (int i = 0; i < 3; i++) begin ser_en = 1'b1; ser_in = 1'b1; tick(); end
    chk("busy_before_reset", busy_a, 1);
    #1 async_clr = 1'b1;
    model_reset();
    #1 chk_reset_outputs("midreset");
    #1 async_clr = 1'b0;
    ser_en = 1'b0;
    tick();
    send_ab(8'h3C, 1'b1, 9, 0);
    send_ab(8'hE4, 1'b0, 9, 0);
    drain();
    chk("post_reset_err", ec_a, 8'd1);
    chk("post_reset_word", po_b, 8'hE4);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
